// File: rtl/player_bullet_pkg.sv
// Shared playfield geometry, speeds and controller state codes for the player cannon/bullet logic.
package player_bullet_pkg;

    localparam int SCREEN_W     = 640;
    localparam int PLAYER_Y     = 440;
    localparam int PLAYER_W     = 26;
    localparam int STEP         = 4;
    localparam int BULLET_SPEED = 8;
    localparam int BULLET_H     = 8;
    localparam int INV_ROWS     = 4;
    localparam int INV_COLS     = 8;
    localparam int INV_W        = 24;
    localparam int INV_H        = 16;
    localparam int INV_XGAP     = 16;
    localparam int INV_YGAP     = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FLY  = 2'd1;
    localparam state_t ST_SCAN = 2'd2;

endpackage

// File: rtl/player_bullet_hit_test.sv
// Combinational bullet-versus-invader box compare for one formation index.
module invader_hit_test
    import player_bullet_pkg::*;
#(
    parameter int N_INV    = INV_ROWS * INV_COLS,
    parameter int COLS     = INV_COLS,
    parameter int BOX_W    = INV_W,
    parameter int BOX_H    = INV_H,
    parameter int XGAP     = INV_XGAP,
    parameter int YGAP     = INV_YGAP,
    parameter int SHOT_H   = BULLET_H
) (
    input  logic [9:0]                 formation_x,
    input  logic [9:0]                 formation_y,
    input  logic [$clog2(N_INV)-1:0]   k,
    input  logic [9:0]                 bullet_x,
    input  logic [9:0]                 bullet_y,
    input  logic                       alive_bit,
    output logic                       hit
);

    logic [10:0] row, col, ix, iy, bx, by;

    // Everything is widened to 11 bits so the box edges never wrap.
    always_comb begin
        row = 11'(k / COLS);
        col = 11'(k % COLS);
        ix  = {1'b0, formation_x} + col * 11'(BOX_W + XGAP);
        iy  = {1'b0, formation_y} + row * 11'(BOX_H + YGAP);
        bx  = {1'b0, bullet_x};
        by  = {1'b0, bullet_y};
        hit = alive_bit
            && (ix <= bx) && (bx < ix + 11'(BOX_W))
            && (by < iy + 11'(BOX_H))
            && (by + 11'(SHOT_H) > iy);
    end

endmodule

// File: rtl/player_bullet.sv
// Cannon movement, single-bullet flight and sequential formation scan producing a one-cycle hit pulse.
module player_bullet
    import player_bullet_pkg::*;
#(
    parameter int SCREEN_W_P     = SCREEN_W,
    parameter int PLAYER_Y_P     = PLAYER_Y,
    parameter int PLAYER_W_P     = PLAYER_W,
    parameter int STEP_P         = STEP,
    parameter int BULLET_SPEED_P = BULLET_SPEED,
    parameter int BULLET_H_P     = BULLET_H,
    parameter int INV_ROWS_P     = INV_ROWS,
    parameter int INV_COLS_P     = INV_COLS,
    parameter int INV_W_P        = INV_W,
    parameter int INV_H_P        = INV_H,
    parameter int INV_XGAP_P     = INV_XGAP,
    parameter int INV_YGAP_P     = INV_YGAP
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      tick,
    input  logic                                      left,
    input  logic                                      right,
    input  logic                                      shoot,
    input  logic [9:0]                                formation_x,
    input  logic [9:0]                                formation_y,
    input  logic [INV_ROWS_P*INV_COLS_P-1:0]          alive,
    output logic [9:0]                                player_x,
    output logic [9:0]                                bullet_x,
    output logic [9:0]                                bullet_y,
    output logic                                      bullet_active,
    output logic                                      invader_collision,
    output logic [$clog2(INV_ROWS_P*INV_COLS_P)-1:0]  hit_index
);

    localparam int N  = INV_ROWS_P * INV_COLS_P;
    localparam int KW = $clog2(N);

    localparam logic [9:0]    X_MAX    = 10'(SCREEN_W_P - PLAYER_W_P);
    localparam logic [9:0]    X_RESET  = 10'((SCREEN_W_P - PLAYER_W_P) / 2);
    localparam logic [9:0]    STEP_V   = 10'(STEP_P);
    localparam logic [9:0]    SPEED_V  = 10'(BULLET_SPEED_P);
    localparam logic [9:0]    MUZZLE_X = 10'(PLAYER_W_P / 2);
    localparam logic [9:0]    SPAWN_Y  = 10'(PLAYER_Y_P - BULLET_H_P);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

    state_t        state;
    logic          pending;
    logic          shoot_q;
    logic [KW-1:0] k;
    logic          hit;

    invader_hit_test #(
        .N_INV  (N),
        .COLS   (INV_COLS_P),
        .BOX_W  (INV_W_P),
        .BOX_H  (INV_H_P),
        .XGAP   (INV_XGAP_P),
        .YGAP   (INV_YGAP_P),
        .SHOT_H (BULLET_H_P)
    ) u_hit_test (
        .formation_x (formation_x),
        .formation_y (formation_y),
        .k           (k),
        .bullet_x    (bullet_x),
        .bullet_y    (bullet_y),
        .alive_bit   (alive[k]),
        .hit         (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            player_x          <= X_RESET;
            bullet_x          <= '0;
            bullet_y          <= '0;
            bullet_active     <= 1'b0;
            invader_collision <= 1'b0;
            hit_index         <= '0;
            state             <= ST_IDLE;
            pending           <= 1'b0;
            shoot_q           <= 1'b0;
            k                 <= '0;
        end else begin
            shoot_q           <= shoot;
            invader_collision <= 1'b0;

            if (tick) begin
                if (left && !right)
                    player_x <= (player_x < STEP_V) ? '0 : player_x - STEP_V;
                else if (right && !left)
                    player_x <= (player_x > X_MAX - STEP_V) ? X_MAX : player_x + STEP_V;
            end

            case (state)
                ST_IDLE: begin
                    if (shoot && !shoot_q) begin
                        bullet_x      <= player_x + MUZZLE_X;
                        bullet_y      <= SPAWN_Y;
                        bullet_active <= 1'b1;
                        state         <= ST_FLY;
                    end
                end
                ST_FLY: begin
                    if (tick || pending) begin
                        pending <= 1'b0;
                        if (bullet_y < SPEED_V) begin
                            bullet_active <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            bullet_y <= bullet_y - SPEED_V;
                            k        <= '0;
                            state    <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    // A tick landing mid-scan is remembered so the bullet still advances once the scan ends.
                    if (tick)
                        pending <= 1'b1;
                    if (hit) begin
                        invader_collision <= 1'b1;
                        hit_index         <= k;
                        bullet_active     <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (k == K_LAST) begin
                        state <= ST_FLY;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_bullet.sv
// Randomized and directed checks of player_bullet against a frame-level reference model.
module tb_player_bullet;

    localparam int N     = 32;
    localparam int X_MAX = 614;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        shoot = 1'b0;
    logic [9:0]  formation_x = '0;
    logic [9:0]  formation_y = '0;
    logic [31:0] alive = '0;
    logic [9:0]  player_x;
    logic [9:0]  bullet_x;
    logic [9:0]  bullet_y;
    logic        bullet_active;
    logic        invader_collision;
    logic [4:0]  hit_index;

    player_bullet dut (
        .clk               (clk),
        .rst               (rst),
        .tick              (tick),
        .left              (left),
        .right             (right),
        .shoot             (shoot),
        .formation_x       (formation_x),
        .formation_y       (formation_y),
        .alive             (alive),
        .player_x          (player_x),
        .bullet_x          (bullet_x),
        .bullet_y          (bullet_y),
        .bullet_active     (bullet_active),
        .invader_collision (invader_collision),
        .hit_index         (hit_index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hits_seen = 0;

    // reference model state
    int m_px, m_bx, m_by, m_hidx;
    bit m_active;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_px = 307; m_bx = 0; m_by = 0; m_hidx = 0; m_active = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // lowest-numbered live invader whose box overlaps the bullet, or -1
    function automatic int first_hit();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                int ix, iy;
                ix = int'(formation_x) + c * 40;
                iy = int'(formation_y) + r * 28;
                if (alive[r*8+c] && ix <= m_bx && m_bx < ix + 24 && m_by < iy + 16 && m_by + 8 > iy)
                    return r * 8 + c;
            end
        return -1;
    endfunction

    task automatic model_cannon(input logic l, input logic r);
        if (l && !r) m_px = (m_px < 4) ? 0 : m_px - 4;
        else if (r && !l) m_px = (m_px + 4 > X_MAX) ? X_MAX : m_px + 4;
    endtask

    task automatic do_tick(input logic l, input logic r);
        int ek, pc, pj, ph, pa;
        ek = -1; pc = 0; pj = -1; ph = 0; pa = 0;
        model_cannon(l, r);
        if (m_active) begin
            if (m_by < 8) m_active = 0;
            else begin
                m_by -= 8;
                ek = first_hit();
            end
        end
        left = l; right = r; tick = 1'b1;
        step();
        tick = 1'b0;
        check("player_x", player_x, m_px);
        check("active_after_tick", bullet_active, m_active);
        if (m_active) check("bullet_y", bullet_y, m_by);
        for (int j = 1; j <= N + 2; j++) begin
            step();
            if (invader_collision) begin
                pc++;
                if (pj < 0) begin
                    pj = j; ph = hit_index; pa = bullet_active;
                end
            end
        end
        hits_seen += pc;
        if (ek >= 0) begin
            m_active = 0;
            m_hidx = ek;
            check("pulse_count", pc, 1);
            check("pulse_latency", pj, ek + 1);
            check("pulse_index", ph, ek);
            check("active_at_pulse", pa, 0);
        end else begin
            check("no_pulse", pc, 0);
        end
        check("active_end", bullet_active, m_active);
        check("hit_index_held", hit_index, m_hidx);
    endtask

    task automatic fire();
        if (!m_active) begin
            m_active = 1; m_bx = m_px + 13; m_by = 432;
        end
        shoot = 1'b1;
        step();
        check("fire_active", bullet_active, m_active);
        check("fire_x", bullet_x, m_bx);
        check("fire_y", bullet_y, m_by);
        shoot = 1'b0;
        step();
    endtask

    task automatic fly_out();
        int n;
        n = 0;
        while (m_active && n < 60) begin
            do_tick(1'b0, 1'b0);
            n++;
        end
        check("flight_bounded", m_active, 0);
    endtask

    initial begin
        int h0, pc;
        model_reset();
        do_reset();
        check("rst_player_x", player_x, 307);
        check("rst_active", bullet_active, 0);
        check("rst_bullet_x", bullet_x, 0);
        check("rst_bullet_y", bullet_y, 0);
        check("rst_collision", invader_collision, 0);
        check("rst_hit_index", hit_index, 0);

        // cannon saturation to the right, then both keys held
        for (int i = 0; i < 200; i++) do_tick(1'b0, 1'b1);
        check("sat_right", player_x, 614);
        do_tick(1'b1, 1'b1);
        check("both_hold", player_x, 614);

        // fire into an empty formation and fly off the top
        do_reset();
        alive = '0; formation_x = 10'd100; formation_y = 10'd50;
        fire();
        check("spawn_x", bullet_x, 320);
        check("spawn_y", bullet_y, 432);
        for (int i = 0; i < 54; i++) do_tick(1'b0, 1'b0);
        check("top_y", bullet_y, 0);
        check("top_active", bullet_active, 1);
        h0 = hits_seen;
        do_tick(1'b0, 1'b0);
        check("despawn_active", bullet_active, 0);
        check("despawn_no_pulse", hits_seen - h0, 0);

        // move to left edge then to x=136 (muzzle 149, inside invader column 1)
        for (int i = 0; i < 77; i++) do_tick(1'b1, 1'b0);
        check("sat_left", player_x, 0);
        for (int i = 0; i < 34; i++) do_tick(1'b0, 1'b1);
        alive = 32'h1 << 9;
        h0 = hits_seen;
        fire();
        fly_out();
        check("single_hit_count", hits_seen - h0, 1);
        check("single_hit_index", hit_index, 9);

        // invaders 1 and 9: nearer row is struck first, then a second shot reaches 1
        alive = (32'h1 << 1) | (32'h1 << 9);
        fire();
        fly_out();
        check("pair_first", hit_index, 9);
        alive = 32'h1 << 1;
        fire();
        check("refire_accepted", bullet_active, 1);
        fly_out();
        check("pair_second", hit_index, 1);

        // shoot edge in flight ignored; tick during scan is deferred
        alive = '0;
        fire();
        do_tick(1'b0, 1'b0);
        fire();
        m_by -= 8;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("pend_first_y", bullet_y, m_by);
        for (int i = 0; i < 4; i++) step();
        tick = 1'b1; right = 1'b1;
        step();
        tick = 1'b0; right = 1'b0;
        model_cannon(1'b0, 1'b1);
        check("pend_cannon", player_x, m_px);
        for (int i = 0; i < 27; i++) step();
        check("pend_not_yet", bullet_y, m_by);
        step();
        m_by -= 8;
        check("pend_advance", bullet_y, m_by);
        pc = 0;
        for (int i = 0; i < N + 4; i++) begin
            step();
            if (invader_collision) pc++;
        end
        check("pend_no_pulse", pc, 0);
        check("pend_active", bullet_active, 1);

        // reset in the middle of a scan that would hit
        alive = '1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("mid_rst_player_x", player_x, 307);
        check("mid_rst_active", bullet_active, 0);
        check("mid_rst_bx", bullet_x, 0);
        check("mid_rst_by", bullet_y, 0);
        check("mid_rst_coll", invader_collision, 0);
        check("mid_rst_idx", hit_index, 0);
        pc = 0;
        for (int i = 0; i < N + 4; i++) begin
            step();
            if (invader_collision) pc++;
        end
        check("mid_rst_no_pulse", pc, 0);

        // randomized rounds
        for (int rnd = 0; rnd < 5; rnd++) begin
            int nmove;
            formation_x = 10'($urandom_range(0, 330));
            formation_y = 10'($urandom_range(0, 250));
            alive = $urandom;
            nmove = $urandom_range(0, 20);
            for (int i = 0; i < nmove; i++)
                do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fire();
            for (int i = 0; i < 60 && m_active; i++) begin
                if ($urandom_range(0, 7) == 0) fire();
                do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            check("rnd_flight_bounded", m_active, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
